bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19: BRAM address width, covering the 540x540 frame of 291600 bytes.
REQ-002 SHALL have parameter DATA_W, default 8: pixel width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal values 1..2: BRAM read latency in cycles from ena_o to valid mem2d_i.
REQ-004 SHALL have parameter MAX_BURST, default 4, minimum 1: maximum beats per grant while the other requester waits.
REQ-005 SHALL have port clk, input, width 1: the single clock; all logic is sampled on its rising edge.
REQ-006 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have ports r0_req_i (in, 1), r0_addr_i (in, ADDR_W), r0_gnt_o (out, 1), r0_rdata_o (out, DATA_W), r0_rvalid_o (out, 1): requester 0, the fetch path, read-only.
REQ-008 SHALL have ports r1_req_i (in, 1), r1_we_i (in, 1), r1_addr_i (in, ADDR_W), r1_wdata_i (in, DATA_W), r1_gnt_o (out, 1), r1_rdata_o (out, DATA_W), r1_rvalid_o (out, 1): requester 1, the writeback path, read/write.
REQ-009 SHALL have ports ena_o (out, 1), wea_o (out, 1), addr_o (out, ADDR_W), d2mem_o (out, DATA_W), mem2d_i (in, DATA_W): the single BRAM port.
REQ-010 SHALL have port busy_o, output, width 1: high when the state is not IDLE or any read is in flight.

Function
REQ-011 SHALL implement FSM states IDLE, OWN0 and OWN1; rN_gnt_o SHALL be registered and high only in state OWNN.
REQ-012 SHALL treat a beat as a rising edge where rN_req_i=1 and rN_gnt_o=1; requesters SHALL hold their address and data stable until that edge.
REQ-013 SHALL, at each beat edge, register ena_o=1, wea_o=(r1_we_i if owner is 1, else 0), addr_o and d2mem_o from the owner; with no beat, the next cycle SHALL show ena_o=0 and wea_o=0.
REQ-014 SHALL assert rN_rvalid_o exactly RD_LAT cycles after each read ena_o cycle, routed to the issuing requester by a tag pipeline; rN_rdata_o SHALL equal mem2d_i, and writes SHALL produce no rvalid.
REQ-015 SHALL, in IDLE, move to OWN0 or OWN1 when any requester is pending, using the arbitration rule in Configuration; there is a one-cycle grant bubble.
REQ-016 SHALL, in OWNN, count beats starting from 0 on entry; when rN_req_i=0, move to the other OWN state if the other requester is pending, otherwise to IDLE.
REQ-017 SHALL, when the beat count reaches MAX_BURST and the other requester is pending, move to the other OWN state after that beat; if the other is not pending, stay in the current state and clear the count.
REQ-018 SHALL update last_served to N on every entry to OWNN.
REQ-019 SHALL allow a back-to-back beat every cycle while one requester owns the port, with no bubble; a read and a write SHALL never be issued in the same cycle.

Reset
REQ-020 SHALL, while rst_n=0, drive all outputs to 0, set state to IDLE, beat count to 0 and last_served to 1, and clear the rvalid/tag pipeline.
REQ-021 SHALL NOT assert any rvalid after a reset that occurs mid-burst, even for reads issued before the reset.

Configuration
REQ-022 SHALL, with BRAM_ARB_RR_EN defined, resolve simultaneous requests in IDLE and at every handover by granting the requester not equal to last_served (round-robin).
REQ-023 SHALL, without BRAM_ARB_RR_EN, always give requester 0 priority on conflict; the MAX_BURST limit from REQ-017 still applies to both requesters.

Verification
REQ-024 SHALL cover: r0 alone reads addresses 0..3 back-to-back -> r0_gnt_o rises 1 cycle after r0_req_i, ena_o is high for 4 consecutive cycles, and r0_rvalid_o is high 4 cycles with data from addresses 0..3 at RD_LAT=1.
REQ-025 SHALL cover: r1 writes 0xA5 to address 291599 then reads it back -> wea_o=1 for 1 cycle, then r1_rvalid_o=1 with r1_rdata_o=0xA5 and r0_rvalid_o=0 throughout.
REQ-026 SHALL cover: both requesters hold req from reset release with RR enabled and MAX_BURST=4 -> r0 gets 4 beats, then r1 gets 4 beats, then r0, alternating with no overlapping grants.
REQ-027 SHALL cover: the same stimulus as REQ-026 without BRAM_ARB_RR_EN -> r0 gets the first grant and gets each handover after an r1 burst of at most 4 beats.
REQ-028 SHALL cover: rst_n pulled low for 2 cycles during an r0 read burst -> all outputs are 0 immediately, no rvalid appears afterward, and the state restarts in IDLE.
REQ-029 SHALL cover: r0 drops req after 2 beats while r1 is pending -> r1_gnt_o is high on the next cycle and busy_o stays 1 until the last rvalid.

Source files
------------

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-requester single-port BRAM arbiter with per-grant burst limit
// Optional round-robin conflict resolution is enabled by defining BRAM_ARB_RR_EN.
module bram_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    output logic              r0_gnt_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r0_rvalid_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_gnt_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              r1_rvalid_o,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] d2mem_o,
    input  logic [DATA_W-1:0] mem2d_i,
    output logic              busy_o
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              beat, burst_done, pick1, ena_tag;
    logic [RD_LAT-1:0] rd_v, rd_tag;

`ifdef BRAM_ARB_RR_EN
    logic last_served;

    // On a tie, favour whichever requester was not granted most recently
    assign pick1 = r1_req_i & (~r0_req_i | ~last_served);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= 1'b1;
        end else if (state_next == OWN0 && state != OWN0) begin
            last_served <= 1'b0;
        end else if (state_next == OWN1 && state != OWN1) begin
            last_served <= 1'b1;
        end
    end
`else
    assign pick1 = r1_req_i & ~r0_req_i;
`endif

    assign r0_gnt_o   = (state == OWN0);
    assign r1_gnt_o   = (state == OWN1);
    assign beat       = (r0_gnt_o & r0_req_i) | (r1_gnt_o & r1_req_i);
    assign burst_done = (cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (r0_req_i || r1_req_i) state_next = pick1 ? OWN1 : OWN0;
            end
            OWN0: begin
                if (!r0_req_i) begin
                    cnt_next   = '0;
                    state_next = r1_req_i ? OWN1 : IDLE;
                end else if (burst_done) begin
                    cnt_next = '0;
                    if (r1_req_i) state_next = OWN1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            OWN1: begin
                if (!r1_req_i) begin
                    cnt_next   = '0;
                    state_next = r0_req_i ? OWN0 : IDLE;
                end else if (burst_done) begin
                    cnt_next = '0;
                    if (r0_req_i) state_next = OWN0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // BRAM port is registered from the owner on each beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_o   <= 1'b0;
            wea_o   <= 1'b0;
            addr_o  <= '0;
            d2mem_o <= '0;
            ena_tag <= 1'b0;
        end else begin
            ena_o   <= beat;
            wea_o   <= beat & r1_gnt_o & r1_we_i;
            ena_tag <= r1_gnt_o;
            if (beat) begin
                addr_o  <= r1_gnt_o ? r1_addr_i : r0_addr_i;
                d2mem_o <= r1_gnt_o ? r1_wdata_i : '0;
            end
        end
    end

    // Read tags travel alongside the BRAM latency so data returns to its issuer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v   <= '0;
            rd_tag <= '0;
        end else begin
            rd_v[0]   <= ena_o & ~wea_o;
            rd_tag[0] <= ena_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i]   <= rd_v[i-1];
                rd_tag[i] <= rd_tag[i-1];
            end
        end
    end

    assign r0_rvalid_o = rd_v[RD_LAT-1] & ~rd_tag[RD_LAT-1];
    assign r1_rvalid_o = rd_v[RD_LAT-1] & rd_tag[RD_LAT-1];
    assign r0_rdata_o  = r0_rvalid_o ? mem2d_i : '0;
    assign r1_rdata_o  = r1_rvalid_o ? mem2d_i : '0;
    assign busy_o      = (state != IDLE) | (ena_o & ~wea_o) | (|rd_v);

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed bench for bram_arbiter with read-return scoreboard
module tb_bram_arbiter;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;
`ifdef BRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              r0_req, r0_gnt, r0_rvalid;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_rdata;
    logic              r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata, r1_rdata;
    logic              ena, wea, busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d2mem;
    logic [DATA_W-1:0] mem2d = '0;

    typedef struct {
        bit          tag;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  rmem [int];
    logic [7:0]  bmem [0:(1<<ADDR_W)-1];
    bit          wv   [0:(1<<ADDR_W)-1];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    bram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_gnt_o(r0_gnt),
        .r0_rdata_o(r0_rdata), .r0_rvalid_o(r0_rvalid),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_gnt_o(r1_gnt), .r1_rdata_o(r1_rdata), .r1_rvalid_o(r1_rvalid),
        .ena_o(ena), .wea_o(wea), .addr_o(addr), .d2mem_o(d2mem), .mem2d_i(mem2d),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
        int k;
        k = int'(a);
        return rmem.exists(k) ? rmem[k] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_ctl"}, 32'({ena, wea, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy}), 32'd0);
        chk({t, "_addr"}, 32'(addr), 32'd0);
        chk({t, "_d2mem"}, 32'(d2mem), 32'd0);
        chk({t, "_rdata"}, 32'({r0_rdata, r1_rdata}), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single-port BRAM with one cycle read latency; unwritten cells hold pat(addr)
    always @(posedge clk) begin
        if (ena) begin
            if (wea) begin
                bmem[addr] <= d2mem;
                wv[addr]   <= 1'b1;
            end else begin
                mem2d <= wv[addr] ? bmem[addr] : pat(addr);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (r0_rvalid || r1_rvalid) begin
            if (sbq.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rv_route", {30'd0, r1_rvalid, r0_rvalid}, e.tag ? 32'd2 : 32'd1);
                chk("rv_data", 32'(e.tag ? r1_rdata : r0_rdata), 32'(e.data));
                chk("rv_cycle", cyc, e.cyc);
            end
        end
        if (rst_n && r0_req && r0_gnt)
            sbq.push_back('{1'b0, ref_rd(r0_addr), cyc + 1 + RD_LAT});
        if (rst_n && r1_req && r1_gnt) begin
            if (r1_we) rmem[int'(r1_addr)] = r1_wdata;
            else sbq.push_back('{1'b1, ref_rd(r1_addr), cyc + 1 + RD_LAT});
        end
    end

    initial begin
        r0_req = 0; r0_addr = '0; r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        rst_n = 0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1;
        tick();

        // r0 alone reads 0..3 back-to-back
        r0_req = 1; r0_addr = '0;
        chk("r0_gnt_pre", 32'(r0_gnt), 32'd0);
        tick();
        chk("r0_gnt_rise", 32'(r0_gnt), 32'd1);
        chk("r0_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("r0_ena_%0d", i), 32'({ena, wea}), 32'd2);
            chk($sformatf("r0_addr_%0d", i), 32'(addr), i);
            if (i < 3) r0_addr = ADDR_W'(i + 1);
            else r0_req = 0;
        end
        tick();
        chk("r0_ena_off", 32'(ena), 32'd0);
        chk("r0_gnt_off", 32'(r0_gnt), 32'd0);
        repeat (3) tick();

        // r1 write 0xA5 to the last pixel then read it back
        r1_req = 1; r1_we = 1; r1_addr = ADDR_W'(291599); r1_wdata = 8'hA5;
        tick();
        chk("r1_gnt", 32'(r1_gnt), 32'd1);
        tick();
        chk("wr_ctl", 32'({ena, wea}), 32'd3);
        chk("wr_addr", 32'(addr), 32'd291599);
        chk("wr_data", 32'(d2mem), 32'hA5);
        r1_we = 0;
        tick();
        chk("rd_ctl", 32'({ena, wea}), 32'd2);
        r1_req = 0;
        tick();
        chk("rb_valid", 32'({r1_rvalid, r0_rvalid}), 32'd2);
        chk("rb_data", 32'(r1_rdata), 32'hA5);
        repeat (3) tick();

        // r0 drops after two beats while r1 waits
        r0_req = 1; r0_addr = ADDR_W'(10); r1_req = 1; r1_we = 0; r1_addr = ADDR_W'(20);
        tick();
        chk("ho_g0_first", 32'({r0_gnt, r1_gnt}), 32'd2);
        tick();
        r0_addr = ADDR_W'(11);
        tick();
        r0_req = 0;
        tick();
        chk("ho_g1_next", 32'({r0_gnt, r1_gnt}), 32'd1);
        chk("ho_busy_a", 32'(busy), 32'd1);
        tick();
        chk("ho_busy_b", 32'(busy), 32'd1);
        r1_req = 0;
        tick();
        chk("ho_busy_c", 32'(busy), 32'd1);
        chk("ho_last_rv", 32'(r1_rvalid), 32'd1);
        tick();
        chk("ho_busy_off", 32'(busy), 32'd0);

        // both held from reset release: alternating bursts of MAX_BURST
        rst_n = 0; sbq.delete();
        r0_req = 1; r0_addr = ADDR_W'(100); r1_req = 1; r1_we = 0; r1_addr = ADDR_W'(200);
        repeat (2) tick();
        rst_n = 1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk($sformatf("alt_g0_%0d", j), 32'(r0_gnt), 32'(((j - 1) / 4) % 2 == 0));
            chk($sformatf("alt_g1_%0d", j), 32'(r1_gnt), 32'(((j - 1) / 4) % 2 == 1));
        end
        r0_req = 0; r1_req = 0;
        repeat (4) tick();

        // tie in IDLE right after r0 was served
        r0_req = 1; r0_addr = ADDR_W'(30);
        tick();
        tick();
        r0_req = 0;
        tick();
        chk("tie_idle", 32'({r0_gnt, r1_gnt}), 32'd0);
        r0_req = 1; r1_req = 1; r1_we = 0; r1_addr = ADDR_W'(40);
        tick();
        chk("tie_g1", 32'(r1_gnt), 32'(RR));
        chk("tie_g0", 32'(r0_gnt), 32'(!RR));
        r0_req = 0; r1_req = 0;
        repeat (3) tick();

        // reset in the middle of an r0 burst
        r0_req = 1; r0_addr = ADDR_W'(50);
        tick();
        tick();
        r0_addr = ADDR_W'(51);
        tick();
        rst_n = 0; sbq.delete();
        #1;
        chk_zero("midrst");
        tick();
        chk("midrst_hold", 32'({r0_gnt, ena}), 32'd0);
        tick();
        rst_n = 1;
        #1;
        chk("post_idle", 32'({r0_gnt, busy}), 32'd0);
        tick();
        chk("post_regrant", 32'(r0_gnt), 32'd1);
        tick();
        r0_req = 0;
        repeat (4) tick();

        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
